// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline stage register for a multi-lane issue bundle.
//
// Carries LANES payloads of DATA_W bits with per-lane valid bits from one
// pipeline stage to the next. The handshake is valid/ready. A bundle whose
// lane-valid mask is all zero is a bubble and is never stored.
//
// SKID_EN selects between two buffer shapes:
//   SKID_EN=1 : main register plus a skid register. in_ready comes from a flop,
//               so there is no combinational path from out_ready to in_ready.
//   SKID_EN=0 : main register only. in_ready is combinational from out_ready,
//               so a new bundle can load in the same cycle the old one leaves.
//
// flush and rst both empty the buffer and clear its contents. A bundle
// presented in the same cycle is discarded. Only rst clears stall_cnt.
// stall_cnt counts the cycles in which a bundle is held and out_ready is low,
// and it saturates at its maximum value.
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous flush; drops every held bundle
//   in_valid   in   [LANES]          per-lane valid of the upstream bundle
//   in_data    in   [LANES*DATA_W]   lane i at [i*DATA_W +: DATA_W]
//   in_ready   out  block accepts a bundle this cycle
//   out_valid  out  [LANES]          lane mask of the held bundle, 0 when empty
//   out_data   out  [LANES*DATA_W]   held payload, same lane packing
//   out_ready  in   downstream consumes the bundle this cycle
//   stall_cnt  out  [CNT_W]          saturating count of stalled cycles
module pipe_stage_buf #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LANES   = 2,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      in_ready,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES*DATA_W-1:0]   out_data,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty,
    StHalf,
    StFull
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e                    state_q;
  logic [LANES-1:0]          main_vld_q;
  logic [LANES*DATA_W-1:0]   main_data_q;
  logic [LANES-1:0]          skid_vld_q;
  logic [LANES*DATA_W-1:0]   skid_data_q;
  logic                      ready_q;
  logic [CNT_W-1:0]          cnt_q;

  logic in_bvalid;
  logic in_fire;
  logic occupied;

  assign in_bvalid = |in_valid;
  assign occupied  = (state_q != StEmpty);
  assign in_fire   = in_bvalid & in_ready;

  // With the skid buffer, ready is a flop that tracks "next state is not FULL".
  // Without it, ready passes out_ready straight through so throughput stays at
  // one bundle per cycle with a single register.
  always_comb begin
    if (SKID_EN != 0) begin
      in_ready = ready_q;
    end else begin
      in_ready = (state_q == StEmpty) | out_ready;
    end
  end

  // Buffer state, contents and the registered ready. flush and rst share the
  // top priority over every handshake event in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q     <= StEmpty;
      main_vld_q  <= '0;
      main_data_q <= '0;
      skid_vld_q  <= '0;
      skid_data_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_q     <= StHalf;
            main_vld_q  <= in_valid;
            main_data_q <= in_data;
          end
        end
        StHalf: begin
          if (in_fire && out_ready) begin
            // Old bundle leaves while the new one takes its place.
            main_vld_q  <= in_valid;
            main_data_q <= in_data;
          end else if (in_fire) begin
            // Only reachable with the skid buffer: park the newcomer behind main.
            state_q     <= StFull;
            skid_vld_q  <= in_valid;
            skid_data_q <= in_data;
            ready_q     <= 1'b0;
          end else if (out_ready) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (out_ready) begin
            state_q     <= StHalf;
            main_vld_q  <= skid_vld_q;
            main_data_q <= skid_data_q;
            ready_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= StEmpty;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Stall counter survives flush so stall statistics span pipeline flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (occupied && !out_ready && !flush && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid = occupied ? main_vld_q : '0;
  assign out_data  = main_data_q;
  assign stall_cnt = cnt_q;

`ifndef SYNTHESIS
  // A stalled bundle must not change under the consumer.
  out_data_stable_a : assert property (@(posedge clk)
    (!rst && !flush && (|out_valid) && !out_ready) |=> $stable(out_data));
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] d;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: defaults (SKID_EN=1, CNT_W=16)
  logic        rst, flush, in_ready, out_ready;
  logic [1:0]  in_valid, out_valid;
  logic [63:0] in_data, out_data;
  logic [15:0] stall_cnt;

  // DUT 1: pass-through ready, 2-bit counter
  logic        rst1, flush1, in_ready1, out_ready1;
  logic [1:0]  in_valid1, out_valid1;
  logic [63:0] in_data1, out_data1;
  logic [1:0]  stall_cnt1;

  pipe_stage_buf #(
    .DATA_W (32),
    .LANES  (2),
    .SKID_EN(1),
    .CNT_W  (16)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_buf #(
    .DATA_W (32),
    .LANES  (2),
    .SKID_EN(0),
    .CNT_W  (2)
  ) u_dut_noskid (
    .clk      (clk),
    .rst      (rst1),
    .flush    (flush1),
    .in_valid (in_valid1),
    .in_data  (in_data1),
    .in_ready (in_ready1),
    .out_valid(out_valid1),
    .out_data (out_data1),
    .out_ready(out_ready1),
    .stall_cnt(stall_cnt1)
  );

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a bundle, wait (bounded) until it is accepted, log the expectation.
  task automatic send(input logic [1:0] v, input logic [63:0] d, input bit lat);
    int   n;
    exp_t e;
    in_valid = v;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready %b expected 1", in_ready);
    end else begin
      e.v   = v;
      e.d   = d;
      e.cyc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    tick();
  endtask

  // Monitor: every consumed bundle must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (|out_valid) && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL mon_unexpected: got %b/%h expected no bundle", out_valid, out_data);
      end else begin
        e = sb.pop_front();
        chk("mon_valid", 64'(out_valid), 64'(e.v));
        chk("mon_data", out_data, e.d);
        if (e.lat) chk("mon_latency", 64'(cyc), 64'(e.cyc + 1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 2'b11; in_data = '1; out_ready = 1'b0;
    rst1 = 1'b1; flush1 = 1'b0; in_valid1 = 2'b00; in_data1 = '0; out_ready1 = 1'b0;

    // Reset for two cycles with a valid bundle on the input
    tick();
    tick();
    rst = 1'b0; rst1 = 1'b0; in_valid = 2'b00; in_data = '0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming, one cycle latency, back-to-back
    tick();
    out_ready = 1'b1;
    send(2'b11, 64'hEEEE_FFFE_1111_0001, 1'b1);
    send(2'b11, 64'hDDDD_FFFD_2222_0002, 1'b1);
    send(2'b11, 64'hCCCC_FFFC_3333_0003, 1'b1);
    in_valid = 2'b00;
    repeat (3) tick();
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // Backpressure: D and E fill the buffer, F waits upstream
    out_ready = 1'b0;
    send(2'b11, 64'h4444_0004_4444_000D, 1'b0);
    send(2'b11, 64'h5555_0005_5555_000E, 1'b0);
    in_valid = 2'b11;
    in_data  = 64'h6666_0006_6666_000F;
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_stall_1", 64'(stall_cnt), 64'd1);
    chk("bp_out_valid", 64'(out_valid), 64'd3);
    chk("bp_out_data_d", out_data, 64'h4444_0004_4444_000D);
    tick();
    @(negedge clk);
    chk("bp_stall_2", 64'(stall_cnt), 64'd2);
    chk("bp_in_ready_low2", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b1;
    send(2'b11, 64'h6666_0006_6666_000F, 1'b0);
    in_valid = 2'b00;
    tick();
    chk("bp_stall_final", 64'(stall_cnt), 64'd3);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Partial lane masks, then a bubble that must not be stored
    send(2'b01, 64'h0BAD_0BAD_5A5A_0001, 1'b1);
    send(2'b10, 64'h7777_0010_0BAD_0BAD, 1'b1);
    in_valid = 2'b00;
    tick();
    out_ready = 1'b0;
    in_data   = 64'h5555_5555_5555_5555;
    tick();
    tick();
    chk("bubble_out_valid", 64'(out_valid), 64'd0);
    chk("bubble_stall", 64'(stall_cnt), 64'd3);
    chk("bubble_in_ready", 64'(in_ready), 64'd1);
    chk("part_drained", 64'(sb.size()), 64'd0);

    // Flush while FULL with a coincident valid bundle
    send(2'b11, 64'h0123_4567_89AB_CDEF, 1'b0);
    send(2'b11, 64'hFEDC_BA98_7654_3210, 1'b0);
    in_valid = 2'b11;
    in_data  = 64'hA5A5_A5A5_A5A5_A5A5;
    flush    = 1'b1;
    @(negedge clk);
    chk("fl_pre_in_ready", 64'(in_ready), 64'd0);
    chk("fl_pre_stall", 64'(stall_cnt), 64'd4);
    tick();
    flush = 1'b0;
    in_valid = 2'b00;
    sb.delete();
    @(negedge clk);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_data", out_data, 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_stall_kept", 64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("fl_discarded", 64'(out_valid), 64'd0);

    // rst clears the stall counter
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_stall", 64'(stall_cnt), 64'd0);

    // No skid buffer: combinational ready and 2-bit saturation
    tick();
    out_ready1 = 1'b1;
    in_valid1  = 2'b11;
    in_data1   = 64'h9999_0009_8888_0008;
    @(negedge clk);
    chk("ns_in_ready_empty", 64'(in_ready1), 64'd1);
    tick();
    in_valid1  = 2'b00;
    out_ready1 = 1'b0;
    @(negedge clk);
    chk("ns_out_valid", 64'(out_valid1), 64'd3);
    chk("ns_out_data", out_data1, 64'h9999_0009_8888_0008);
    chk("ns_in_ready_low", 64'(in_ready1), 64'd0);
    #1 out_ready1 = 1'b1;
    #1 chk("ns_in_ready_comb_hi", 64'(in_ready1), 64'd1);
    out_ready1 = 1'b0;
    #1 chk("ns_in_ready_comb_lo", 64'(in_ready1), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk("ns_stall", 64'(stall_cnt1), 64'((i + 1 < 3) ? i + 1 : 3));
    end
    out_ready1 = 1'b1;
    tick();
    @(negedge clk);
    chk("ns_drained", 64'(out_valid1), 64'd0);
    chk("ns_stall_held", 64'(stall_cnt1), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
